text_link_pipe: RTL
===================

# text_link_pipe

Parametrised single-clock text link that carries DATA_W-bit characters through a full loopback chain: stream encryption, framing with optional even parity, bit-serial BPSK symbol mapping, a deterministic error-injecting channel, demodulation, deframing, parity check and decryption. It replaces the fixed 7-bit, handshake-less loopback top with a valid/ready input and a one-cycle output strobe. Error-detection statistics are exposed for the text demo path. Every stage is sequenced by one FSM, so latency is exact and testable.

## Interface
- DATA_W, 7, character width in bits (1..15)
- KEY, 16'h007B, LFSR seed; 0 is replaced by 16'h0001 at load
- PARITY, 1, 1 appends an even-parity bit to each frame; 0 sends no parity bit
- ERR_PERIOD, 0, 0 disables injection; N>0 flips every N-th channel bit

- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- in_valid  in  1  character offered
- in_ready  out  1  block can accept; high only in IDLE
- data_in  in  DATA_W  plaintext character
- out_valid  out  1  one-cycle strobe, data_out valid
- data_out  out  DATA_W  decrypted character; holds until the next strobe
- out_parity_err  out  1  parity mismatch for the current data_out; 0 when PARITY=0
- err_count  out  16  parity errors since reset, saturating at 16'hFFFF
- tx_symbol  out  2  modulator symbol: +1=2'b01, -1=2'b11, none=2'b00
- rx_symbol  out  2  channel output symbol, same encoding
- busy  out  1  high in any state other than IDLE

## Operation
- F = DATA_W + PARITY bits per frame.
- Keystream: a 16-bit Galois LFSR. Each step is lsb=l[0]; l=l>>1; if lsb, l ^= 16'hB400. The key ks is l[DATA_W-1:0]. The LFSR loads KEY on reset and advances exactly one step per delivered character, in DELIVER.
- States:
  - IDLE: in_ready=1. When in_valid is high: cipher = data_in ^ ks, frame = {parity(cipher), cipher} (parity omitted when PARITY=0), bit index = 0, go to TX.
  - TX: send frame bit index (LSB first) this cycle. Map 1 to +1 and 0 to -1 on tx_symbol. When injection applies, rx_symbol is the negated tx_symbol; otherwise rx_symbol = tx_symbol. The demodulator decides rx_symbol +1 as 1 and -1 as 0 and shifts the bit into the receive register. After bit F-1, go to DELIVER.
  - DELIVER: data_out = rx_cipher ^ ks. out_parity_err = parity of the received frame is odd (PARITY=1). err_count increments on error and saturates. out_valid=1. The LFSR steps. Go to IDLE.
- Injection: a global channel-bit counter, modulo ERR_PERIOD, runs across frames and is cleared only by reset. The bit at counter value ERR_PERIOD-1 is flipped. With ERR_PERIOD=1, every bit is flipped.
- Parity detects only odd numbers of flipped bits. An even number of flips delivers corrupted data with out_parity_err=0; this is required behaviour.
- in_valid outside IDLE is ignored; the character is not accepted and not queued.

## Timing
- Reset values: in_ready=1, busy=0, out_valid=0, data_out=0, out_parity_err=0, err_count=0, tx_symbol=rx_symbol=2'b00. The LFSR holds KEY and the injection counter is 0.
- Accept at cycle A, when IDLE, in_valid and in_ready are all high.
- Frame bit i appears on tx_symbol and rx_symbol in cycle A+1+i, for i = 0..F-1.
- out_valid is high in cycle A+F+1 only. in_ready rises again in cycle A+F+2. Throughput is one character per F+2 cycles.
- tx_symbol and rx_symbol are 2'b00 outside TX.
- Reset asserted in any state aborts the frame. The next cycle shows all reset values; no out_valid is produced for the aborted character.
- Reset overrides in_valid in the same cycle.

## Test plan
- Defaults, ERR_PERIOD=0, send 0x41 at cycle A:
  - tx bits, LSB first, from cipher 0x3A (0x41 ^ 0x7B) with parity 0: 0,1,0,1,1,1,0,0.
  - data_out=0x41 and out_parity_err=0, with out_valid exactly at A+9.
- Back-to-back 0x41 then 0x41: the second cipher uses ks=0x3D (LFSR 16'hB43D), so tx cipher bits are 0x7C. Both outputs are 0x41, and the second is accepted at A+10.
- ERR_PERIOD=8, three characters: the parity bit of each frame is flipped. data_out is intact, out_parity_err=1 on each strobe, and err_count reaches 3.
- ERR_PERIOD=3, first character 0x41: bits 2 and 5 are flipped. data_out=0x41 ^ 0x24 = 0x65 and out_parity_err=0; two flips are undetected.
- Reset asserted in TX at bit 3:
  - No out_valid follows, and reset values appear the next cycle.
  - A fresh 0x41 again produces cipher 0x3A, showing the LFSR is back at KEY.
- PARITY=0, DATA_W=8, send 0xFF:
  - F=8 and out_valid at A+9, with out_parity_err held at 0.
  - in_valid pulses during busy are ignored, with no extra strobes.

Source files
------------

// File: rtl/text_link_pipe.sv
// Purpose: loopback text link that encrypts, frames, BPSK-maps, corrupts, demodulates and decrypts one character.
// Latency: accept at A, frame bit i on the symbols at A+1+i, out_valid at A+F+1, ready again at A+F+2.
// Backpressure: in_ready is high only in IDLE; in_valid outside IDLE is ignored, never queued.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   in_valid/in_ready     character handshake; data_in is the plaintext character
//   out_valid             one-cycle strobe; data_out/out_parity_err hold until the next strobe
//   err_count             saturating count of parity errors since reset
//   tx_symbol/rx_symbol   channel symbols (+1=01, -1=11, none=00), non-zero only while transmitting
//   busy                  high whenever the FSM is not in IDLE
module text_link_pipe #(
  parameter int          DATA_W     = 7,
  parameter logic [15:0] KEY        = 16'h007B,
  parameter int          PARITY     = 1,
  parameter int          ERR_PERIOD = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] data_in,
  output logic              out_valid,
  output logic [DATA_W-1:0] data_out,
  output logic              out_parity_err,
  output logic [15:0]       err_count,
  output logic [1:0]        tx_symbol,
  output logic [1:0]        rx_symbol,
  output logic              busy
);

  localparam int F     = DATA_W + PARITY;
  localparam int IDX_W = 5;
  // An all-zero seed would lock the LFSR at zero forever.
  localparam logic [15:0]      SEED     = (KEY == 16'h0000) ? 16'h0001 : KEY;
  localparam logic [IDX_W-1:0] LAST_BIT = IDX_W'(F - 1);
  localparam logic [15:0]      ERR_LAST = (ERR_PERIOD > 0) ? 16'(ERR_PERIOD - 1) : 16'd0;

  localparam logic [1:0] SYM_POS  = 2'b01;
  localparam logic [1:0] SYM_NEG  = 2'b11;
  localparam logic [1:0] SYM_NONE = 2'b00;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_TX      = 2'd1,
    S_DELIVER = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;

  logic [15:0]       lfsr;
  logic [DATA_W-1:0] ks;
  logic [DATA_W-1:0] cipher;
  logic [F-1:0]      tx_frame;
  logic [F-1:0]      tx_shift;
  logic [F-1:0]      rx_shift;
  logic [F-1:0]      rx_frame_nxt;
  logic [IDX_W-1:0]  bit_idx;
  logic [15:0]       inj_cnt;
  logic              tx_bit;
  logic              flip;
  logic              rx_bit;
  logic              last_bit;

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    lfsr_step = {1'b0, l[15:1]} ^ (l[0] ? 16'hB400 : 16'h0000);
  endfunction

  assign ks     = lfsr[DATA_W-1:0];
  assign cipher = data_in ^ ks;

  generate
    if (PARITY != 0) begin : g_par
      assign tx_frame = {^cipher, cipher};
    end else begin : g_nopar
      assign tx_frame = cipher;
    end
  endgenerate

  // Frame goes out LSB first from a right-shifting register.
  assign tx_bit   = tx_shift[0];
  assign flip     = (ERR_PERIOD > 0) && (inj_cnt == ERR_LAST);
  assign rx_bit   = tx_bit ^ flip;
  assign last_bit = (bit_idx == LAST_BIT);

  // Received bits enter at the top so the first bit ends up in bit 0.
  generate
    if (F > 1) begin : g_rx_wide
      assign rx_frame_nxt = {rx_bit, rx_shift[F-1:1]};
    end else begin : g_rx_one
      assign rx_frame_nxt = rx_bit;
    end
  endgenerate

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:    if (in_valid) state_nxt = S_TX;
      S_TX:      if (last_bit) state_nxt = S_DELIVER;
      S_DELIVER: state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    in_ready  = (state == S_IDLE);
    busy      = (state != S_IDLE);
    out_valid = (state == S_DELIVER);
    tx_symbol = SYM_NONE;
    rx_symbol = SYM_NONE;
    if (state == S_TX) begin
      tx_symbol = tx_bit ? SYM_POS : SYM_NEG;
      rx_symbol = rx_bit ? SYM_POS : SYM_NEG;
    end
  end

  // Datapath
  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr           <= SEED;
      tx_shift       <= '0;
      rx_shift       <= '0;
      bit_idx        <= '0;
      inj_cnt        <= 16'd0;
      data_out       <= '0;
      out_parity_err <= 1'b0;
      err_count      <= 16'd0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (in_valid) begin
            tx_shift <= tx_frame;
            bit_idx  <= '0;
          end
        end
        S_TX: begin
          tx_shift <= tx_shift >> 1;
          rx_shift <= rx_frame_nxt;
          bit_idx  <= bit_idx + 1'b1;
          // Channel-bit counter spans frames; only reset clears it.
          if (ERR_PERIOD > 0) inj_cnt <= flip ? 16'd0 : inj_cnt + 16'd1;
          // Decode from the completed frame so data_out is stable in the strobe cycle.
          if (last_bit) begin
            data_out       <= rx_frame_nxt[DATA_W-1:0] ^ ks;
            out_parity_err <= (PARITY != 0) && (^rx_frame_nxt);
          end
        end
        S_DELIVER: begin
          lfsr <= lfsr_step(lfsr);
          if (out_parity_err && (err_count != 16'hFFFF)) err_count <= err_count + 16'd1;
        end
        default: ;
      endcase
    end
  end

endmodule
